// File: rtl/lfsr_encrypt_engine.sv
// Program-1 engine: reads the config bytes and the biased message from data memory,
// then writes 64 LFSR-encrypted, space-padded bytes back to the output region.
module lfsr_encrypt_engine #(
  parameter int MSG_BASE  = 0,
  parameter int CFG_BASE  = 61,
  parameter int OUT_BASE  = 64,
  parameter int NUM_CHARS = 64,
  parameter int PRE_MIN   = 10,
  parameter int PRE_MAX   = 26,
  parameter int PARITY_EN = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       ack,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [7:0] MSG_B   = 8'(MSG_BASE);
  localparam logic [7:0] CFG_B   = 8'(CFG_BASE);
  localparam logic [7:0] OUT_B   = 8'(OUT_BASE);
  localparam logic [7:0] PMIN_B  = 8'(PRE_MIN);
  localparam logic [7:0] PMAX_B  = 8'(PRE_MAX);
  localparam logic [6:0] LAST_I  = 7'(NUM_CHARS - 1);

  typedef enum logic [2:0] {IDLE, CFG0, CFG1, CFG2, CFG3, RD, WR, DONE} state_t;

  state_t     state;
  logic [6:0] idx;
  logic [6:0] lfsr;
  logic [6:0] taps;
  logic [7:0] pre;
  logic [6:0] ch;
  logic [7:0] wbyte;

  function automatic logic [7:0] clamp_pre(input logic [7:0] v);
    if (v < PMIN_B)      return PMIN_B;
    else if (v > PMAX_B) return PMAX_B;
    else                 return v;
  endfunction

  function automatic logic parity7(input logic [6:0] v);
    return ^v;
  endfunction

  // Padding positions (i < pre) need no read; the address is parked at the message base.
  function automatic logic [7:0] rd_addr(input logic [6:0] i, input logic [7:0] p);
    if ({1'b0, i} >= p) return MSG_B + ({1'b0, i} - p);
    else                return MSG_B;
  endfunction

  // Write data follows the synchronous-read data, so it is formed during the WR cycle.
  always_comb begin
    ch    = 7'h00;
    wbyte = 8'h00;
    if (mem_wr_en) begin
      ch         = ({1'b0, idx} < pre) ? 7'h00 : mem_rdata[6:0];
      wbyte[6:0] = ch ^ lfsr;
      wbyte[7]   = (PARITY_EN != 0) ? parity7(ch ^ lfsr) : 1'b0;
    end else begin
      wbyte = 8'h00;
    end
  end

  assign mem_wdata = wbyte;

  // Sequencer: registered outputs are loaded on the edge that enters each state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ack       <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= 8'h00;
      idx       <= 7'h00;
      lfsr      <= 7'h00;
      taps      <= 7'h00;
      pre       <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          ack       <= 1'b0;
          mem_wr_en <= 1'b0;
          if (!start) begin
            state    <= CFG0;
            mem_addr <= CFG_B;
          end else begin
            mem_addr <= 8'h00;
          end
        end
        CFG0: begin
          state    <= CFG1;
          mem_addr <= CFG_B + 8'd1;
        end
        CFG1: begin
          pre      <= clamp_pre(mem_rdata);
          state    <= CFG2;
          mem_addr <= CFG_B + 8'd2;
        end
        CFG2: begin
          taps  <= mem_rdata[6:0];
          state <= CFG3;
        end
        CFG3: begin
          lfsr     <= (mem_rdata[6:0] == 7'h00) ? 7'h01 : mem_rdata[6:0];
          idx      <= 7'h00;
          mem_addr <= rd_addr(7'h00, pre);
          state    <= RD;
        end
        RD: begin
          mem_addr  <= OUT_B + {1'b0, idx};
          mem_wr_en <= 1'b1;
          state     <= WR;
        end
        WR: begin
          mem_wr_en <= 1'b0;
          lfsr      <= {lfsr[5:0], ^(lfsr & taps)};
          idx       <= idx + 7'd1;
          if (idx == LAST_I) begin
            state    <= DONE;
            ack      <= 1'b1;
            mem_addr <= 8'h00;
          end else begin
            state    <= RD;
            mem_addr <= rd_addr(idx + 7'd1, pre);
          end
        end
        DONE: begin
          mem_wr_en <= 1'b0;
          if (start) begin
            state <= IDLE;
            ack   <= 1'b0;
          end else begin
            ack <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ack       <= 1'b0;
          mem_wr_en <= 1'b0;
          mem_addr  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Bench for lfsr_encrypt_engine: two instances (parity off/on) over a shared stimulus,
// checked against a plain-arithmetic model of the encryption rules.
module tb_lfsr_encrypt_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ack0, ack1;
  logic [7:0] addr0, addr1;
  logic       we0, we1;
  logic [7:0] wd0, wd1;
  logic [7:0] rd0, rd1;

  logic [7:0] init_mem [0:63];
  logic [7:0] out0 [0:63];
  logic [7:0] out1 [0:63];
  logic [7:0] exp0 [0:63];
  logic [7:0] exp1 [0:63];
  int wcnt0 = 0;
  int wcnt1 = 0;
  int badw  = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_encrypt_engine #(.PARITY_EN(0)) dut_p0 (
    .clk(clk), .reset(reset), .start(start), .ack(ack0), .mem_addr(addr0),
    .mem_wr_en(we0), .mem_wdata(wd0), .mem_rdata(rd0));

  lfsr_encrypt_engine #(.PARITY_EN(1)) dut_p1 (
    .clk(clk), .reset(reset), .start(start), .ack(ack1), .mem_addr(addr1),
    .mem_wr_en(we1), .mem_wdata(wd1), .mem_rdata(rd1));

  // Synchronous-read data memories; the output region is captured separately.
  always @(posedge clk) begin
    rd0 <= init_mem[addr0[5:0]];
    rd1 <= init_mem[addr1[5:0]];
    if (we0) begin
      out0[addr0[5:0]] <= wd0;
      wcnt0 <= wcnt0 + 1;
      if (addr0 < 8'd64) badw <= badw + 1;
    end
    if (we1) begin
      out1[addr1[5:0]] <= wd1;
      wcnt1 <= wcnt1 + 1;
      if (addr1 < 8'd64) badw <= badw + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_msg(input int mode);
    for (int a = 0; a < 61; a++) begin
      if (a >= 54)        init_mem[a] = 8'h00;
      else if (mode == 0) init_mem[a] = (a < 35) ? 8'h20 : 8'h00;
      else if (mode == 1) init_mem[a] = 8'h00;
      else                init_mem[a] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic build_model(input int pre_raw, input int taps_raw, input int init_raw);
    int p, l, tp, c, e;
    p  = (pre_raw < 10) ? 10 : ((pre_raw > 26) ? 26 : pre_raw);
    tp = taps_raw & 127;
    l  = init_raw & 127;
    if (l == 0) l = 1;
    for (int i = 0; i < 64; i++) begin
      c = (i < p) ? 0 : (int'(init_mem[i - p]) & 127);
      e = c ^ l;
      exp0[i] = 8'(e);
      exp1[i] = 8'(e | (($countones(e) % 2) << 7));
      l = ((l << 1) | ($countones(l & tp) % 2)) & 127;
    end
  endtask

  task automatic launch_and_wait(input string name);
    int n, w0, w1;
    w0 = wcnt0;
    w1 = wcnt1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack0 && n < 400);
    check({name, "_ack_edges"}, n, 133);
    check({name, "_ack_p1"}, ack1, 1'b1);
    @(posedge clk);
    #1;
    check({name, "_ack_hold"}, ack0, 1'b1);
    check({name, "_writes_p0"}, wcnt0 - w0, 64);
    check({name, "_writes_p1"}, wcnt1 - w1, 64);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s_p0_byte%0d", name, i), out0[i], exp0[i]);
      check($sformatf("%s_p1_byte%0d", name, i), out1[i], exp1[i]);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_ack_drop"}, ack0, 1'b0);
  endtask

  task automatic set_cfg(input int pre_raw, input int taps_raw, input int init_raw);
    init_mem[61] = 8'(pre_raw);
    init_mem[62] = 8'(taps_raw);
    init_mem[63] = 8'(init_raw);
    build_model(pre_raw, taps_raw, init_raw);
  endtask

  initial begin
    logic [7:0] first11 [0:10];
    int pr, tp, ip;
    first11 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03, 8'h06, 8'h0C, 8'h38};
    reset = 1'b0;
    start = 1'b1;
    #1;
    check("rst_ack", ack0, 1'b0);
    check("rst_we", we0, 1'b0);
    check("rst_addr", addr0, 8'h00);
    check("rst_wdata", wd0, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reference scenario and its fixed expected bytes.
    fill_msg(0);
    set_cfg(10, 8'h60, 8'h01);
    launch_and_wait("base");
    for (int i = 0; i < 11; i++) check($sformatf("base_const%0d", i), out0[i], first11[i]);
    check("par_64", out1[0], 8'h81);
    check("par_65", out1[1], 8'h82);
    check("par_70", out1[6], 8'h41);

    set_cfg(5, 8'h60, 8'h01);
    launch_and_wait("pre5");
    for (int i = 0; i < 11; i++) check($sformatf("pre5_const%0d", i), out0[i], first11[i]);

    fill_msg(1);
    set_cfg(30, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 127)));
    launch_and_wait("pre30");

    fill_msg(0);
    set_cfg(10, 8'h60, 8'h00);
    launch_and_wait("init0");
    check("init0_dm64", out0[0], 8'h01);

    fill_msg(2);
    set_cfg(8'hFF, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    launch_and_wait("preFF");

    // Reset in the middle of a run, then a clean rerun.
    fill_msg(2);
    set_cfg(14, 8'h60, 8'h05);
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    reset = 1'b0;
    start = 1'b1;
    #1;
    check("midrst_ack", ack0, 1'b0);
    check("midrst_we0", we0, 1'b0);
    check("midrst_we1", we1, 1'b0);
    check("midrst_addr", addr0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    launch_and_wait("rerun");

    for (int k = 0; k < 4; k++) begin
      fill_msg(2);
      pr = $urandom_range(0, 255);
      tp = $urandom_range(0, 255);
      ip = $urandom_range(0, 255);
      set_cfg(pr, tp, ip);
      launch_and_wait($sformatf("rand%0d", k));
    end

    check("no_low_writes", badw, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
